dram_arb: RTL
=============

# dram_arb

Two-port request/grant arbiter that shares one single-port, synchronous-read 4Kx32 data RAM between the two pipeline memory stages (pipe 1, pipe 2). It replaces double-edge time-multiplexing with a single-clock pipelined schedule. Each cycle it accepts at most one access, issues it to the RAM the following cycle, and returns read data to the owning port. It sits between the MEM stages of both pipelines and the RAM macro.

## Interface
- ADDR_W, 12, RAM word-address width; higher address bits ignored
- DATA_W, 32, data width
- CLK  in  1  clock, all logic on posedge
- RST  in  1  asynchronous, active-high reset
- REQ1, REQ2  in  1  access request; held with its command until granted
- R_W1, R_W2  in  1  0 = write, 1 = read
- ADDR1, ADDR2  in  32  word address
- WDATA1, WDATA2  in  DATA_W  write data
- GNT1, GNT2  out  1  command accepted this cycle (combinational)
- RVALID1, RVALID2  out  1  one-cycle pulse: RDATAx valid
- RDATA1, RDATA2  out  DATA_W  read data, held until that port's next RVALID
- ram_cs  out  1  RAM chip select
- ram_rw  out  1  0 write, 1 read
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read with ram_cs=1

## Operation
- Three stages: ARB (cycle N), ISSUE (N+1), RESP (N+2).
- ARB: if exactly one REQx, grant it. If both, the winner is set by the policy (see Configuration). GNTx is asserted combinationally in cycle N. The command is latched into the issue register (valid, port, rw, addr[ADDR_W-1:0], wdata) at posedge end of N.
- At most one GNT per cycle. A granted port's command is consumed at that posedge; the port may present a new command in N+1.
- ISSUE: the issue register drives ram_cs=valid, ram_rw, ram_addr and ram_wdata directly from registers. When invalid: ram_cs=0, ram_rw=1, addr and wdata 0.
- RESP: for reads, a response register (valid, port) is set at the end of ISSUE. In N+2, RDATA(port) is loaded from ram_rdata, and RVALID(port) pulses the cycle after that load. Read-to-RVALID latency is 3 cycles after GNT.
- Writes produce no response.
- Ordering is the grant order. A read granted after a write to the same address returns the new data, because RAM accesses are serialized.
- Grant state: a 1-bit last-winner pointer, updated only when both requested.

## Timing
- Reset values: GNTx=0 while RST=1. RVALIDx=0, RDATAx=0, ram_cs=0, ram_rw=1, ram_addr=0, ram_wdata=0, issue/response valid=0, pointer=last-winner=pipe 2 (so pipe 1 wins first).
- Reset mid-operation: any in-flight write may or may not land. In-flight reads are dropped and produce no RVALID after reset release.
- Throughput is 1 access per cycle. With both ports requesting continuously, each port is granted every other cycle.
- Simultaneous read and write from different ports in the same cycle: only the winner proceeds, and the loser keeps REQ asserted.
- REQx must not be deasserted before GNTx. Command changes while waiting are legal, and the value present at the GNT cycle is taken.
- ADDR bits [31:ADDR_W] are discarded, so the RAM address wraps modulo 2^ADDR_W.

## Configuration
- DRAM_ARB_RR_EN defined: round-robin on conflict. The port that did not win the last conflict wins.
- Undefined: fixed priority, pipe 1 always wins a conflict. The pointer register is removed, and pipe 2 can starve under continuous pipe 1 requests.

## Structure
- Package dram_pkg: RW_WRITE=1'b0, RW_READ=1'b1, PORT1=1'b0, PORT2=1'b1, and issue/response record typedefs.
- Sub-module dram_arb_pick: 2-way picker with inputs req[1:0] and last-winner, outputs gnt[1:0] and winner. It contains the macro-selected policy.

## Test plan
- Single read: REQ2=1, R_W2=1, ADDR2=0x10 with RAM[0x10]=0xDEADBEEF -> GNT2 in N, ram_cs=1 with ram_addr=0x10 in N+1, RVALID2 pulse and RDATA2=0xDEADBEEF after three cycles, GNT1/RVALID1 stay 0.
- Write then read cross-port: pipe 1 writes 0x12345678 to 0x004, then pipe 2 reads 0x004 -> RDATA2=0x12345678.
- Conflict, continuous requests, both reads: with DRAM_ARB_RR_EN, grants alternate 1,2,1,2. Without it, GNT1 every cycle and GNT2 never.
- Address wrap: read with ADDR1=0x00001FFC -> ram_addr=0xFFC.
- Back-to-back reads on pipe 1 to 0x1 then 0x2 -> two consecutive RVALID1 pulses carrying RAM[0x1] then RAM[0x2].
- Assert RST one cycle after a read GNT -> all outputs reset immediately, and no RVALID appears after release.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared constants and record types for the dram_arb two-port RAM arbiter.
package dram_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic PORT1    = 1'b0;
    localparam logic PORT2    = 1'b1;

    // One accepted command waiting to be driven onto the RAM pins.
    typedef struct packed {
        logic              valid;
        logic              port;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } issue_t;

    // A read that is in the RAM and whose data lands next cycle.
    typedef struct packed {
        logic valid;
        logic port;
    } resp_t;

endpackage

// File: rtl/dram_arb_if.sv
// Pipe-side and RAM-side signal bundle for dram_arb.
interface dram_arb_if;
    import dram_pkg::*;

    // Handshake: a pipe raises REQx with its command (R_Wx, ADDRx, WDATAx)
    // and holds REQx until GNTx is seen high in the same cycle; the command
    // present in that cycle is the one taken. Reads answer with a one-cycle
    // RVALIDx pulse, RDATAx holding its value until the next pulse.
    logic              REQ1;
    logic              REQ2;
    logic              R_W1;
    logic              R_W2;
    logic [31:0]       ADDR1;
    logic [31:0]       ADDR2;
    logic [DATA_W-1:0] WDATA1;
    logic [DATA_W-1:0] WDATA2;
    logic              GNT1;
    logic              GNT2;
    logic              RVALID1;
    logic              RVALID2;
    logic [DATA_W-1:0] RDATA1;
    logic [DATA_W-1:0] RDATA2;

    logic              ram_cs;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter view.
    modport slave (
        input  REQ1, REQ2, R_W1, R_W2, ADDR1, ADDR2, WDATA1, WDATA2, ram_rdata,
        output GNT1, GNT2, RVALID1, RVALID2, RDATA1, RDATA2,
        output ram_cs, ram_rw, ram_addr, ram_wdata
    );

    // Pipeline and RAM view.
    modport master (
        output REQ1, REQ2, R_W1, R_W2, ADDR1, ADDR2, WDATA1, WDATA2, ram_rdata,
        input  GNT1, GNT2, RVALID1, RVALID2, RDATA1, RDATA2,
        input  ram_cs, ram_rw, ram_addr, ram_wdata
    );

endinterface

// File: rtl/dram_arb_pick.sv
// Two-way request picker. Conflict policy chosen by DRAM_ARB_RR_EN:
// defined = round-robin against the last conflict winner,
// undefined = pipe 1 always wins a conflict.
module dram_arb_pick
    import dram_pkg::*;
(
    input  logic [1:0] req_i,          // bit 0 = pipe 1, bit 1 = pipe 2
    input  logic       last_winner_i,
    output logic [1:0] gnt_o,
    output logic       winner_o
);

    // Choose the winning port and grant only that one.
    always_comb begin
        winner_o = PORT1;
        if (req_i[0] && req_i[1]) begin
`ifdef DRAM_ARB_RR_EN
            winner_o = (last_winner_i == PORT1) ? PORT2 : PORT1;
`else
            winner_o = PORT1;
`endif
        end else if (req_i[1]) begin
            winner_o = PORT2;
        end
        gnt_o[0] = req_i[0] && (winner_o == PORT1);
        gnt_o[1] = req_i[1] && (winner_o == PORT2);
    end

`ifndef DRAM_ARB_RR_EN
    // Fixed priority has no use for the history input.
    logic unused_last_winner;
    assign unused_last_winner = last_winner_i;
`endif

endmodule

// File: rtl/dram_arb.sv
// Two-port arbiter sharing one synchronous-read RAM: ARB -> ISSUE -> RESP.
// DRAM_ARB_RR_EN selects round-robin conflict resolution; without it pipe 1
// has fixed priority and the last-winner pointer does not exist.
module dram_arb
    import dram_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    dram_arb_if.slave  bus
);

    logic [1:0] req_w;
    logic [1:0] pick_gnt;
    logic [1:0] gnt_w;
    logic       winner;
    logic       last_q;

    issue_t issue_q, issue_d;
    resp_t  resp_q,  resp_d;

    logic              rvalid1_q, rvalid1_d;
    logic              rvalid2_q, rvalid2_d;
    logic [DATA_W-1:0] rdata1_q,  rdata1_d;
    logic [DATA_W-1:0] rdata2_q,  rdata2_d;

    // Address bits above the RAM depth are dropped on purpose (wrap).
    logic [2*(32-ADDR_W)-1:0] unused_addr_hi;
    assign unused_addr_hi = {bus.ADDR1[31:ADDR_W], bus.ADDR2[31:ADDR_W]};

    assign req_w = {bus.REQ2, bus.REQ1};

    dram_arb_pick u_pick (
        .req_i         (req_w),
        .last_winner_i (last_q),
        .gnt_o         (pick_gnt),
        .winner_o      (winner)
    );

    // Grants are combinational but forced low while reset is held.
    assign gnt_w    = pick_gnt & {2{~RST}};
    assign bus.GNT1 = gnt_w[0];
    assign bus.GNT2 = gnt_w[1];

`ifdef DRAM_ARB_RR_EN
    logic last_d;

    // The pointer only moves when both ports competed.
    always_comb begin
        last_d = last_q;
        if (&req_w) last_d = winner;
    end

    // Last-winner pointer; pipe 2 after reset so pipe 1 wins first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) last_q <= PORT2;
        else     last_q <= last_d;
    end
`else
    assign last_q = PORT2;
`endif

    // Capture the granted command; an idle slot parks the RAM in read mode.
    always_comb begin
        issue_d    = '0;
        issue_d.rw = RW_READ;
        if (|gnt_w) begin
            issue_d.valid = 1'b1;
            issue_d.port  = winner;
            if (winner == PORT1) begin
                issue_d.rw    = bus.R_W1;
                issue_d.addr  = bus.ADDR1[ADDR_W-1:0];
                issue_d.wdata = bus.WDATA1;
            end else begin
                issue_d.rw    = bus.R_W2;
                issue_d.addr  = bus.ADDR2[ADDR_W-1:0];
                issue_d.wdata = bus.WDATA2;
            end
        end
    end

    // Only reads need a response slot; writes finish at the RAM.
    always_comb begin
        resp_d.valid = issue_q.valid && (issue_q.rw == RW_READ);
        resp_d.port  = issue_q.port;
    end

    // Route returning RAM data to its owner and pulse that port's valid next.
    always_comb begin
        rvalid1_d = resp_q.valid && (resp_q.port == PORT1);
        rvalid2_d = resp_q.valid && (resp_q.port == PORT2);
        rdata1_d  = rvalid1_d ? bus.ram_rdata : rdata1_q;
        rdata2_d  = rvalid2_d ? bus.ram_rdata : rdata2_q;
    end

    // Pipeline registers; reset drops every in-flight access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            issue_q    <= '0;
            issue_q.rw <= RW_READ;
            resp_q     <= '0;
            rvalid1_q  <= 1'b0;
            rvalid2_q  <= 1'b0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
        end else begin
            issue_q    <= issue_d;
            resp_q     <= resp_d;
            rvalid1_q  <= rvalid1_d;
            rvalid2_q  <= rvalid2_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
        end
    end

    assign bus.ram_cs    = issue_q.valid;
    assign bus.ram_rw    = issue_q.rw;
    assign bus.ram_addr  = issue_q.addr;
    assign bus.ram_wdata = issue_q.wdata;
    assign bus.RVALID1   = rvalid1_q;
    assign bus.RVALID2   = rvalid2_q;
    assign bus.RDATA1    = rdata1_q;
    assign bus.RDATA2    = rdata2_q;

endmodule
